spi_master_rx_mc: RTL and testbench

Parametrised multi-lane receive engine for the SPI master. It samples one, two or four SDI lanes on each `rx_edge` strobe from the clock generator and packs them into `DATA_WIDTH`-bit words, MSB-first or LSB-first. Words go to the RX FIFO over a registered valid/ready port, and a final partial word is right-aligned and flagged `data_last`. Under FIFO backpressure the block stalls the SPI clock through `clk_en_o`, so no data is lost.

---
 rtl/spi_master_rx_mc_if.sv | 26 ++
 rtl/spi_master_rx_mc.sv | 195 +++++++++++++++++++
 tb/tb_spi_master_rx_mc.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_rx_mc_if.sv
// -----------------------------------------------------------------------------
// spi_master_rx_mc_if
// Output word port between the SPI receive engine and the RX FIFO.
//
// Handshake: the producer raises data_valid with data/data_last and holds all
// three stable until a cycle where data_valid & data_ready are both high; the
// word transfers in exactly that cycle. data_ready may toggle freely.
//
// Signals:
//   data       [DATA_WIDTH] received word (partial words right-aligned)
//   data_valid             word present
//   data_ready             consumer accepts the word this cycle
//   data_last              word is the final one of the transfer
// Modports: master (receive engine), slave (FIFO side / testbench).
// -----------------------------------------------------------------------------
interface spi_master_rx_mc_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  data_ready;
    logic                  data_last;

    modport master (output data, output data_valid, output data_last, input data_ready);
    modport slave  (input data, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/spi_master_rx_mc.sv
// -----------------------------------------------------------------------------
// spi_master_rx_mc
// Multi-lane SPI receive engine. Samples 1, 2 or 4 SDI lanes on each rx_edge
// strobe, packs them MSB- or LSB-first into DATA_WIDTH-bit words and hands the
// words to the RX FIFO through a one-entry registered output. When a word
// completes while the output register is still occupied, the SPI clock is
// stalled via clk_en_o until the word can be stored.
//
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   en               start request (IDLE only)
//   rx_edge          one-cycle SPI sampling strobe (RECEIVE only)
//   sdi[3:0]         data lanes
//   mode[1:0]        00 single, 01 dual, 10 quad, 11 single
//   lsb_first        bit order of the packed word
//   counter_in       total bit count, loaded by counter_in_upd in IDLE
//   fifo             output word port (master modport)
//   rx_done          one-cycle pulse the cycle after the final word loads
//   clk_en_o         SPI clock enable
//   state[1:0]       FSM state for observation: 0 IDLE, 1 RECEIVE, 2 WAIT_OUT
// -----------------------------------------------------------------------------
module spi_master_rx_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 rx_edge,
    input  logic [3:0]           sdi,
    input  logic [1:0]           mode,
    input  logic                 lsb_first,
    input  logic [CNT_WIDTH-1:0] counter_in,
    input  logic                 counter_in_upd,
    spi_master_rx_mc_if.master   fifo,
    output logic                 rx_done,
    output logic                 clk_en_o,
    output logic [1:0]           state
);
    localparam int WCW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t               st;
    logic [1:0]           lane_log2;     // log2 of active lane count, latched at start
    logic                 lsb_q;
    logic [CNT_WIDTH-1:0] nbits;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic [CNT_WIDTH+1:0] edge_target;
    logic [WCW-1:0]       word_cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic                 held_last;

    logic [1:0]           start_log2;
    logic [CNT_WIDTH+1:0] round_add;
    logic [CNT_WIDTH+1:0] start_target;
    logic [CNT_WIDTH-1:0] edge_cnt_nx;
    logic [WCW-1:0]       word_cnt_nx;
    logic [WCW-1:0]       word_edges;
    logic [WCW-1:0]       word_bits;
    logic [WCW-1:0]       align_shift;
    logic [DATA_WIDTH-1:0] sr_nx;
    logic [DATA_WIDTH-1:0] word;
    logic                 final_edge;
    logic                 word_done;
    logic                 can_load;
    logic                 stall;

    // Edge target for the transfer about to start: ceil(nbits / L), computed
    // two bits wider than the counter so the rounding add cannot overflow.
    always_comb begin
        start_log2 = 2'd0;
        case (mode)
            2'b01:   start_log2 = 2'd1;
            2'b10:   start_log2 = 2'd2;
            default: start_log2 = 2'd0;
        endcase
        round_add    = ((CNT_WIDTH+2)'(1) << start_log2) - (CNT_WIDTH+2)'(1);
        start_target = ({2'b00, nbits} + round_add) >> start_log2;
    end

    always_comb begin
        sr_nx = sr;
        case (lane_log2)
            2'd1:    sr_nx = lsb_q ? {sdi[1:0], sr[DATA_WIDTH-1:2]} : {sr[DATA_WIDTH-3:0], sdi[1:0]};
            2'd2:    sr_nx = lsb_q ? {sdi[3:0], sr[DATA_WIDTH-1:4]} : {sr[DATA_WIDTH-5:0], sdi[3:0]};
            default: sr_nx = lsb_q ? {sdi[0], sr[DATA_WIDTH-1:1]}   : {sr[DATA_WIDTH-2:0], sdi[0]};
        endcase

        edge_cnt_nx = edge_cnt + CNT_WIDTH'(1);
        word_cnt_nx = word_cnt + WCW'(1);
        word_edges  = WCW'(DATA_WIDTH >> lane_log2);
        word_bits   = word_cnt_nx << lane_log2;
        align_shift = WCW'(DATA_WIDTH) - word_bits;

        final_edge = ({2'b00, edge_cnt_nx} == edge_target);
        word_done  = final_edge || (word_cnt_nx == word_edges);

        // LSB-first groups enter at the top, so a short final word must be
        // moved down to bit 0. MSB-first words already sit right-aligned.
        word = lsb_q ? (sr_nx >> align_shift) : sr_nx;

        can_load = !fifo.data_valid || fifo.data_ready;
        stall    = (st == RECEIVE) && rx_edge && word_done && !can_load;
        clk_en_o = (st == RECEIVE) && !stall;
    end

    assign state = st;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st              <= IDLE;
            lane_log2       <= 2'd0;
            lsb_q           <= 1'b0;
            nbits           <= CNT_WIDTH'(8);
            edge_cnt        <= '0;
            edge_target     <= '0;
            word_cnt        <= '0;
            sr              <= '0;
            held_last       <= 1'b0;
            fifo.data       <= '0;
            fifo.data_valid <= 1'b0;
            fifo.data_last  <= 1'b0;
            rx_done         <= 1'b0;
        end else begin
            rx_done <= 1'b0;

            // Consumer took the word; any load below overrides this.
            if (fifo.data_valid && fifo.data_ready) begin
                fifo.data_valid <= 1'b0;
            end

            case (st)
                IDLE: begin
                    if (counter_in_upd) begin
                        nbits <= counter_in;
                    end
                    if (en && (nbits != '0)) begin
                        st          <= RECEIVE;
                        lane_log2   <= start_log2;
                        lsb_q       <= lsb_first;
                        edge_target <= start_target;
                        edge_cnt    <= '0;
                        word_cnt    <= '0;
                        sr          <= '0;
                    end
                end

                RECEIVE: begin
                    if (rx_edge) begin
                        edge_cnt <= edge_cnt_nx;
                        if (word_done) begin
                            word_cnt <= '0;
                            if (can_load) begin
                                fifo.data       <= word;
                                fifo.data_valid <= 1'b1;
                                fifo.data_last  <= final_edge;
                                rx_done         <= final_edge;
                                sr              <= '0;
                                if (final_edge) begin
                                    st <= IDLE;
                                end
                            end else begin
                                // Park the aligned word until the output frees.
                                sr        <= word;
                                held_last <= final_edge;
                                st        <= WAIT_OUT;
                            end
                        end else begin
                            word_cnt <= word_cnt_nx;
                            sr       <= sr_nx;
                        end
                    end
                end

                WAIT_OUT: begin
                    if (can_load) begin
                        fifo.data       <= sr;
                        fifo.data_valid <= 1'b1;
                        fifo.data_last  <= held_last;
                        rx_done         <= held_last;
                        sr              <= '0;
                        st              <= held_last ? IDLE : RECEIVE;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_rx_mc.sv
module tb_spi_master_rx_mc;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          rx_edge;
    logic [3:0]    sdi;
    logic [1:0]    mode;
    logic          lsb_first;
    logic [CW-1:0] counter_in;
    logic          counter_in_upd;
    logic          rx_done;
    logic          clk_en_o;
    logic [1:0]    state;

    spi_master_rx_mc_if #(.DATA_WIDTH(DW)) fifo_if ();

    spi_master_rx_mc #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .sdi            (sdi),
        .mode           (mode),
        .lsb_first      (lsb_first),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .fifo           (fifo_if.master),
        .rx_done        (rx_done),
        .clk_en_o       (clk_en_o),
        .state          (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [DW-1:0] mon_d;
    logic          mon_l;
    logic          rand_ready = 1'b0;

    always @(negedge clk) begin
        if (rstn && fifo_if.data_valid && fifo_if.data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got data=%h last=%b", fifo_if.data, fifo_if.data_last);
            end else begin
                mon_d = exp_q.pop_front();
                mon_l = exp_last_q.pop_front();
                if (fifo_if.data !== mon_d || fifo_if.data_last !== mon_l) begin
                    errors++;
                    $display("FAIL word got data=%h last=%b expected data=%h last=%b",
                             fifo_if.data, fifo_if.data_last, mon_d, mon_l);
                end
            end
        end
        if (rstn && rx_done) begin
            done_cnt++;
            checks++;
            if (!(fifo_if.data_valid && fifo_if.data_last)) begin
                errors++;
                $display("FAIL rx_done_align got valid=%b last=%b expected 1 1",
                         fifo_if.data_valid, fifo_if.data_last);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            fifo_if.data_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l);
        exp_q.push_back(d);
        exp_last_q.push_back(l);
    endtask

    task automatic start_xfer(input logic upd, input int nb, input logic [1:0] m, input logic lsb);
        if (upd) begin
            counter_in     = CW'(nb);
            counter_in_upd = 1'b1;
            tick();
            counter_in_upd = 1'b0;
        end
        mode      = m;
        lsb_first = lsb;
        en        = 1'b1;
        tick();
        en        = 1'b0;
    endtask

    // One strobe followed by one idle cycle; ce is clk_en_o seen during the strobe.
    task automatic drive_edge(input logic [3:0] l, output logic ce);
        sdi     = l;
        rx_edge = 1'b1;
        #1;
        ce = clk_en_o;
        tick();
        rx_edge = 1'b0;
        tick();
    endtask

    task automatic wait_not_stalled();
        int n = 0;
        while (state == 2'd2 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (state == 2'd2) begin
            errors++;
            $display("FAIL stall_timeout got state=%0d expected not 2", state);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || state != 2'd0 || fifo_if.data_valid) && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || state != 2'd0 || fifo_if.data_valid) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d state=%0d valid=%b expected 0 0 0",
                     exp_q.size(), state, fifo_if.data_valid);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (state !== 2'd0 || clk_en_o !== 1'b0) begin
            errors++;
            $display("FAIL %s got state=%0d clk_en=%b expected 0 0", name, state, clk_en_o);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (fifo_if.data !== '0 || fifo_if.data_valid !== 1'b0 || fifo_if.data_last !== 1'b0 ||
            rx_done !== 1'b0 || clk_en_o !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL %s got data=%h valid=%b last=%b done=%b clk_en=%b state=%0d expected all 0",
                     name, fifo_if.data, fifo_if.data_valid, fifo_if.data_last, rx_done, clk_en_o, state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_quad_word();
        logic ce;
        logic all_ce = 1'b1;
        int   d0 = done_cnt;
        push_exp(32'h12345678, 1'b1);
        start_xfer(1'b1, 32, 2'b10, 1'b0);
        checks++;
        if (clk_en_o !== 1'b1 || state !== 2'd1) begin
            errors++;
            $display("FAIL start_latency got clk_en=%b state=%0d expected 1 1", clk_en_o, state);
        end
        for (int i = 1; i <= 8; i++) begin
            drive_edge(4'(i), ce);
            all_ce &= ce;
        end
        checks++;
        if (all_ce !== 1'b1) begin
            errors++;
            $display("FAIL quad_clk_en got %b expected 1", all_ce);
        end
        check_idle("quad_end");
        wait_drain();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL quad_rx_done got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_single_partial_msb();
        logic ce;
        logic [31:0] w  = 32'hDEADBEEF;
        logic [7:0]  b  = 8'hA5;
        push_exp(32'hDEADBEEF, 1'b0);
        push_exp(32'h000000A5, 1'b1);
        start_xfer(1'b1, 40, 2'b00, 1'b0);
        for (int i = 31; i >= 0; i--) drive_edge({3'b000, w[i]}, ce);
        for (int i = 7; i >= 0; i--)  drive_edge({3'b000, b[i]}, ce);
        check_idle("single_msb_end");
        wait_drain();
    endtask

    task automatic test_single_partial_lsb();
        logic ce;
        logic [7:0] serial = 8'b1010_0101;  // bit i is the i-th bit sent
        push_exp(32'h000000A5, 1'b1);
        start_xfer(1'b1, 8, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) drive_edge({3'b111, serial[i]}, ce);
        check_idle("single_lsb_end");
        wait_drain();
    endtask

    task automatic test_dual_rounding();
        logic ce;
        int   d0 = done_cnt;
        push_exp(32'h00000036, 1'b1);
        start_xfer(1'b1, 5, 2'b01, 1'b0);
        drive_edge(4'b0011, ce);
        drive_edge(4'b1101, ce);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL dual_mid got state=%0d expected 1", state);
        end
        drive_edge(4'b0110, ce);
        check_idle("dual_end");
        wait_drain();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL dual_rx_done got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        logic ce;
        logic all_ce = 1'b1;
        logic [31:0] w1 = $urandom;
        logic [31:0] w2 = $urandom;
        int   d0 = done_cnt;
        fifo_if.data_ready = 1'b0;
        push_exp(w1, 1'b0);
        push_exp(w2, 1'b1);
        start_xfer(1'b1, 64, 2'b00, 1'b0);
        for (int i = 31; i >= 0; i--) begin
            drive_edge({3'b000, w1[i]}, ce);
            all_ce &= ce;
        end
        for (int i = 31; i >= 1; i--) begin
            drive_edge({3'b000, w2[i]}, ce);
            all_ce &= ce;
            if (i == 16) begin
                checks++;
                if (fifo_if.data !== w1 || fifo_if.data_valid !== 1'b1 || fifo_if.data_last !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold got data=%h valid=%b last=%b expected %h 1 0",
                             fifo_if.data, fifo_if.data_valid, fifo_if.data_last, w1);
                end
            end
        end
        checks++;
        if (all_ce !== 1'b1) begin
            errors++;
            $display("FAIL bp_clk_en_before_stall got %b expected 1", all_ce);
        end
        sdi     = {3'b000, w2[0]};
        rx_edge = 1'b1;
        #1;
        checks++;
        if (clk_en_o !== 1'b0 || state !== 2'd1) begin
            errors++;
            $display("FAIL bp_stall_edge got clk_en=%b state=%0d expected 0 1", clk_en_o, state);
        end
        tick();
        rx_edge = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 2'd2 || clk_en_o !== 1'b0 || fifo_if.data !== w1 || fifo_if.data_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_wait_out got state=%0d clk_en=%b data=%h last=%b expected 2 0 %h 0",
                         state, clk_en_o, fifo_if.data, fifo_if.data_last, w1);
            end
            tick();
        end
        fifo_if.data_ready = 1'b1;
        wait_drain();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bp_rx_done got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_ignored_inputs();
        logic ce;
        logic [7:0] b1 = 8'($urandom);
        logic [7:0] b2 = 8'($urandom);
        push_exp({24'h0, b1}, 1'b1);
        start_xfer(1'b1, 8, 2'b00, 1'b0);
        for (int i = 7; i >= 5; i--) drive_edge({3'b000, b1[i]}, ce);
        counter_in     = CW'(16);
        counter_in_upd = 1'b1;
        for (int i = 4; i >= 1; i--) drive_edge({3'b000, b1[i]}, ce);
        counter_in_upd = 1'b0;
        drive_edge({3'b000, b1[0]}, ce);
        check_idle("upd_ignored_first");
        wait_drain();
        push_exp({24'h0, b2}, 1'b1);
        start_xfer(1'b0, 0, 2'b00, 1'b0);
        for (int i = 7; i >= 0; i--) drive_edge({3'b000, b2[i]}, ce);
        check_idle("upd_ignored_second");
        wait_drain();
    endtask

    task automatic test_reset_mid();
        logic ce;
        logic [7:0] b = 8'($urandom);
        fifo_if.data_ready = 1'b0;
        start_xfer(1'b1, 40, 2'b00, 1'b0);
        for (int i = 0; i < 35; i++) drive_edge(4'($urandom_range(0, 15)), ce);
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        fifo_if.data_ready = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        push_exp({24'h0, b}, 1'b1);
        start_xfer(1'b0, 0, 2'b00, 1'b0);
        for (int i = 7; i >= 0; i--) drive_edge({3'b000, b[i]}, ce);
        check_idle("reset_default_nbits");
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic        all_ce = 1'b1;
        logic [31:0] acc = '0;
        logic [3:0]  nib;
        push_exp('0, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_last_q.pop_back());
        start_xfer(1'b1, 64, 2'b10, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nib = 4'($urandom_range(0, 15));
            acc = {acc[27:0], nib};
            if (i % 8 == 7) push_exp(acc, i == 15);
            sdi     = nib;
            rx_edge = 1'b1;
            #1;
            all_ce &= clk_en_o;
            tick();
        end
        rx_edge = 1'b0;
        checks++;
        if (all_ce !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clk_en got %b expected 1", all_ce);
        end
        wait_drain();
    endtask

    task automatic test_random();
        logic ce;
        rand_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [1:0]  m   = 2'($urandom_range(0, 3));
            logic        lsb = 1'($urandom_range(0, 1));
            int          nb  = $urandom_range(1, 80);
            int          l   = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
            int          e   = (nb + l - 1) / l;
            int          w   = DW / l;
            int          k   = 0;
            logic [31:0] acc = '0;
            logic [31:0] lv;
            logic [3:0]  nib;
            start_xfer(1'b1, nb, m, lsb);
            for (int i = 1; i <= e; i++) begin
                nib = 4'($urandom_range(0, 15));
                lv  = 32'(nib) & ((32'd1 << l) - 32'd1);
                if (lsb) acc = acc | (lv << (l * k));
                else     acc = (acc << l) | lv;
                k++;
                if (k == w || i == e) begin
                    push_exp(acc, i == e);
                    acc = '0;
                    k   = 0;
                end
                drive_edge(nib, ce);
                wait_not_stalled();
            end
            checks++;
            if (state !== 2'd0) begin
                errors++;
                $display("FAIL rand_end got state=%0d expected 0 (nb=%0d mode=%0d)", state, nb, m);
            end
            wait_drain();
        end
        rand_ready = 1'b0;
        tick();
        fifo_if.data_ready = 1'b1;
        tick();
    endtask

    initial begin
        rstn               = 1'b0;
        en                 = 1'b0;
        rx_edge            = 1'b0;
        sdi                = 4'h0;
        mode               = 2'b00;
        lsb_first          = 1'b0;
        counter_in         = '0;
        counter_in_upd     = 1'b0;
        fifo_if.data_ready = 1'b1;
        tick();
        tick();
        test_reset();
        rstn = 1'b1;
        tick();
        test_quad_word();
        test_single_partial_msb();
        test_single_partial_lsb();
        test_dual_rounding();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_words got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
